// File: rtl/nand_bus_pkg.sv
// Shared types and default timing for the NAND bus chip-select slice.
package nand_bus_pkg;

  localparam int         NUM_CHIPS_DEF    = 8;
  localparam int         DQ_W_DEF         = 8;
  localparam logic [7:0] REV_MASK_DEF     = 8'hF0;
  localparam int         SYNC_STAGES_DEF  = 2;
  localparam int         TWB_CYCLES_DEF   = 10;
  localparam int         CE_SETUP_DEF     = 2;
  localparam int         CE_HOLD_DEF      = 2;
  localparam int         BUSY_TIMEOUT_DEF = 2**20;

  localparam int CHIP_IDX_W = $clog2(NUM_CHIPS_DEF);
  typedef logic [CHIP_IDX_W-1:0] chip_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_OWNED,
    ST_HOLD
  } cs_state_t;

endpackage

// File: rtl/nand_chip_sel_ctrl_if.sv
// Controller-side bus between the flash bus engine and the chip-select manager.
interface nand_chip_sel_ctrl_if #(
  parameter int NUM_CHIPS = 8,
  parameter int DQ_W      = 8
);
  localparam int IDX_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

  logic                 req_valid;
  logic [IDX_W-1:0]     req_chip;
  logic                 req_ready;
  logic                 rel;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_chip;
  logic                 cmd_issued;
  logic                 err_clr;
  logic [NUM_CHIPS-1:0] chip_busy;
  logic [NUM_CHIPS-1:0] timeout_err;
  logic [DQ_W-1:0]      dq_tx_in;
  logic [DQ_W-1:0]      dq_rx_out;

  modport master (
    output req_valid, req_chip, rel, cmd_issued, err_clr, dq_tx_in,
    input  req_ready, grant_valid, grant_chip, chip_busy, timeout_err, dq_rx_out
  );

  modport slave (
    input  req_valid, req_chip, rel, cmd_issued, err_clr, dq_tx_in,
    output req_ready, grant_valid, grant_chip, chip_busy, timeout_err, dq_rx_out
  );
endinterface

// File: rtl/nand_rb_tracker.sv
// Per-chip R/B# tracker: synchroniser, tWB blanking, busy flag and sticky busy timeout.
module nand_rb_tracker #(
  parameter int SYNC_STAGES  = 2,
  parameter int TWB_CYCLES   = 10,
  parameter int BUSY_TIMEOUT = 2**20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rb_n,
  input  logic cmd_set,
  input  logic err_clr,
  output logic busy,
  output logic timeout_err
);
  localparam int BLANK_W = (TWB_CYCLES > 0) ? $clog2(TWB_CYCLES + 1) : 1;
  localparam int CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(TWB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(BUSY_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [BLANK_W-1:0]     blank_reg, blank_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   busy_reg, busy_next;
  logic                   err_reg, err_next;
  logic                   rb_s;

  assign rb_s        = sync_reg[SYNC_STAGES-1];
  assign busy        = busy_reg;
  assign timeout_err = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '1;
      blank_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], rb_n};
      blank_reg <= blank_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    blank_next = blank_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    err_next   = err_reg;
    if (blank_reg != '0)
      blank_next = blank_reg - 1'b1;
    if (busy_reg && (cnt_reg != CNT_MAX))
      cnt_next = cnt_reg + 1'b1;
    // R/B# is only trusted once the tWB window has fully elapsed
    if (blank_reg == '0) begin
      if (busy_reg && rb_s) begin
        busy_next = 1'b0;
        cnt_next  = '0;
      end else if (!busy_reg && !rb_s) begin
        busy_next = 1'b1;
        cnt_next  = '0;
      end
    end
    if (cmd_set) begin
      busy_next  = 1'b1;
      blank_next = BLANK_LOAD;
      cnt_next   = '0;
    end
    if (err_clr)
      err_next = 1'b0;
    // flag only on the increment that lands on the limit, so a clear sticks while saturated
    if ((cnt_next == CNT_MAX) && (cnt_reg != CNT_MAX))
      err_next = 1'b1;
  end
endmodule

// File: rtl/nand_chip_sel_ctrl.sv
// NAND bus owner: one-hot CEN arbitration with setup/hold, per-chip R/B# tracking, DQ swizzle.
module nand_chip_sel_ctrl
  import nand_bus_pkg::*;
#(
  parameter int                   NUM_CHIPS    = NUM_CHIPS_DEF,
  parameter int                   DQ_W         = DQ_W_DEF,
  parameter logic [NUM_CHIPS-1:0] REV_MASK     = NUM_CHIPS'(REV_MASK_DEF),
  parameter int                   SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int                   TWB_CYCLES   = TWB_CYCLES_DEF,
  parameter int                   CE_SETUP     = CE_SETUP_DEF,
  parameter int                   CE_HOLD      = CE_HOLD_DEF,
  parameter int                   BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_chip_sel_ctrl_if.slave  bus,
  input  logic [NUM_CHIPS-1:0] rb_n_in,
  output logic [NUM_CHIPS-1:0] cen,
  output logic [DQ_W-1:0]      dq_tx_out,
  input  logic [DQ_W-1:0]      dq_rx_in
);
  localparam int IDX_W   = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
  localparam int T_MAX   = (CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD;
  localparam int TCNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  cs_state_t            state_reg, state_next;
  logic [IDX_W-1:0]     chip_reg, chip_next;
  logic [TCNT_W-1:0]    tcnt_reg, tcnt_next;
  logic                 cmd_fire;
  logic [NUM_CHIPS-1:0] busy_vec, terr_vec;
  logic [DQ_W-1:0]      tx_rev, rx_rev;
  logic                 rev_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      chip_reg  <= '0;
      tcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      chip_reg  <= chip_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    chip_next  = chip_reg;
    tcnt_next  = tcnt_reg;
    case (state_reg)
      ST_IDLE: if (bus.req_valid) begin
        chip_next = bus.req_chip;
        tcnt_next = '0;
        if (CE_SETUP == 0) state_next = ST_OWNED;
        else               state_next = ST_SETUP;
      end
      ST_SETUP: if (int'(tcnt_reg) >= CE_SETUP - 1) state_next = ST_OWNED;
                else tcnt_next = tcnt_reg + 1'b1;
      ST_OWNED: if (bus.rel) begin
        tcnt_next = '0;
        if (CE_HOLD == 0) state_next = ST_IDLE;
        else              state_next = ST_HOLD;
      end
      ST_HOLD: if (int'(tcnt_reg) >= CE_HOLD - 1) state_next = ST_IDLE;
               else tcnt_next = tcnt_reg + 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

  // CEN follows the state register only, so async reset releases every chip at once
  always_comb begin
    cen = '1;
    if (state_reg != ST_IDLE)
      cen[chip_reg] = 1'b0;
  end

  assign bus.req_ready   = (state_reg == ST_IDLE);
  assign bus.grant_valid = (state_reg == ST_OWNED);
  assign bus.grant_chip  = chip_reg;
  assign cmd_fire        = (state_reg == ST_OWNED) && bus.cmd_issued;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHIPS; gi++) begin : g_rb
      nand_rb_tracker #(
        .SYNC_STAGES  (SYNC_STAGES),
        .TWB_CYCLES   (TWB_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
      ) u_rb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rb_n        (rb_n_in[gi]),
        .cmd_set     (cmd_fire && (chip_reg == IDX_W'(gi))),
        .err_clr     (bus.err_clr),
        .busy        (busy_vec[gi]),
        .timeout_err (terr_vec[gi])
      );
    end
    for (gi = 0; gi < DQ_W; gi++) begin : g_rev
      assign tx_rev[gi] = bus.dq_tx_in[DQ_W-1-gi];
      assign rx_rev[gi] = dq_rx_in[DQ_W-1-gi];
    end
  endgenerate

  assign bus.chip_busy   = busy_vec;
  assign bus.timeout_err = terr_vec;

  assign rev_sel       = REV_MASK[chip_reg];
  assign dq_tx_out     = rev_sel ? tx_rev : bus.dq_tx_in;
  assign bus.dq_rx_out = rev_sel ? rx_rev : dq_rx_in;

  a_cen_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~cen));
endmodule

// File: tb/tb_nand_chip_sel_ctrl.sv
// Directed bench for nand_chip_sel_ctrl: grant timing, swizzle, R/B# blanking, timeout, edge cases.
module tb_nand_chip_sel_ctrl;
  import nand_bus_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rb_n_in;
  logic [7:0] cen;
  logic [7:0] dq_tx_out;
  logic [7:0] dq_rx_in;
  int         checks;
  int         failures;

  nand_chip_sel_ctrl_if #(.NUM_CHIPS(8), .DQ_W(8)) bus_if ();

  nand_chip_sel_ctrl #(
    .NUM_CHIPS(8), .DQ_W(8), .REV_MASK(8'hF0), .SYNC_STAGES(2),
    .TWB_CYCLES(10), .CE_SETUP(2), .CE_HOLD(2), .BUSY_TIMEOUT(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if.slave),
    .rb_n_in   (rb_n_in),
    .cen       (cen),
    .dq_tx_out (dq_tx_out),
    .dq_rx_in  (dq_rx_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_grant(input chip_idx_t chip);
    bus_if.req_valid = 1'b1;
    bus_if.req_chip  = chip;
    tick(1);
    bus_if.req_valid = 1'b0;
    tick(2);
  endtask

  task automatic do_release();
    bus_if.rel = 1'b1;
    tick(1);
    bus_if.rel = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rb_n_in = 8'hFF;
    dq_rx_in = 8'h00;
    bus_if.req_valid = 1'b0; bus_if.req_chip = '0; bus_if.rel = 1'b0;
    bus_if.cmd_issued = 1'b0; bus_if.err_clr = 1'b0; bus_if.dq_tx_in = 8'h00;
    tick(3);
    if (cen !== 8'hFF) begin failures++; $display("FAIL reset_cen got=%h exp=ff", cen); end
    checks++;
    if (bus_if.grant_valid !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", bus_if.grant_valid); end
    checks++;
    if (bus_if.grant_chip !== 3'd0) begin failures++; $display("FAIL reset_grant_chip got=%0d exp=0", bus_if.grant_chip); end
    checks++;
    if (bus_if.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus_if.req_ready); end
    checks++;
    if (bus_if.chip_busy !== 8'h00) begin failures++; $display("FAIL reset_busy got=%h exp=00", bus_if.chip_busy); end
    checks++;
    if (bus_if.timeout_err !== 8'h00) begin failures++; $display("FAIL reset_terr got=%h exp=00", bus_if.timeout_err); end
    checks++;
    rst_n = 1'b1;
    tick(3);
    $display("test_reset done");
  endtask

  task automatic test_grant_timing();
    bus_if.req_valid = 1'b1;
    bus_if.req_chip  = 3'd3;
    tick(1);
    bus_if.req_valid = 1'b0;
    if (cen !== 8'hF7) begin failures++; $display("FAIL grant_cen_setup got=%h exp=f7", cen); end
    checks++;
    if (bus_if.req_ready !== 1'b0) begin failures++; $display("FAIL grant_ready_setup got=%b exp=0", bus_if.req_ready); end
    checks++;
    tick(1);
    if (bus_if.grant_valid !== 1'b0) begin failures++; $display("FAIL grant_early got=%b exp=0", bus_if.grant_valid); end
    checks++;
    tick(1);
    if (bus_if.grant_valid !== 1'b1 || bus_if.grant_chip !== 3'd3) begin
      failures++; $display("FAIL grant_owned got=%b/%0d exp=1/3", bus_if.grant_valid, bus_if.grant_chip);
    end
    checks++;
    bus_if.rel = 1'b1;
    tick(1);
    bus_if.rel = 1'b0;
    if (bus_if.grant_valid !== 1'b0 || cen !== 8'hF7) begin
      failures++; $display("FAIL hold_first got=%b/%h exp=0/f7", bus_if.grant_valid, cen);
    end
    checks++;
    tick(1);
    if (cen !== 8'hF7) begin failures++; $display("FAIL hold_second got=%h exp=f7", cen); end
    checks++;
    tick(1);
    if (cen !== 8'hFF || bus_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL hold_done got=%h/%b exp=ff/1", cen, bus_if.req_ready);
    end
    checks++;
    $display("test_grant_timing done");
  endtask

  task automatic test_dq_reverse();
    do_grant(3'd5);
    bus_if.dq_tx_in = 8'h01; dq_rx_in = 8'hC0;
    #1;
    if (dq_tx_out !== 8'h80) begin failures++; $display("FAIL rev_tx got=%h exp=80", dq_tx_out); end
    checks++;
    if (bus_if.dq_rx_out !== 8'h03) begin failures++; $display("FAIL rev_rx got=%h exp=03", bus_if.dq_rx_out); end
    checks++;
    bus_if.dq_tx_in = 8'h12;
    #1;
    if (dq_tx_out !== 8'h48) begin failures++; $display("FAIL rev_tx2 got=%h exp=48", dq_tx_out); end
    checks++;
    do_release();
    do_grant(3'd1);
    bus_if.dq_tx_in = 8'h01;
    #1;
    if (dq_tx_out !== 8'h01) begin failures++; $display("FAIL pass_tx got=%h exp=01", dq_tx_out); end
    checks++;
    if (bus_if.dq_rx_out !== 8'hC0) begin failures++; $display("FAIL pass_rx got=%h exp=c0", bus_if.dq_rx_out); end
    checks++;
    do_release();
    $display("test_dq_reverse done");
  endtask

  task automatic test_twb_blank();
    do_grant(3'd2);
    bus_if.cmd_issued = 1'b1;
    tick(1);
    bus_if.cmd_issued = 1'b0;
    if (bus_if.chip_busy[2] !== 1'b1) begin failures++; $display("FAIL twb_set got=%b exp=1", bus_if.chip_busy[2]); end
    checks++;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (bus_if.chip_busy[2] !== 1'b1) begin failures++; $display("FAIL twb_hold_%0d got=%b exp=1", i, bus_if.chip_busy[2]); end
      checks++;
    end
    tick(1);
    if (bus_if.chip_busy[2] !== 1'b0) begin failures++; $display("FAIL twb_clear got=%b exp=0", bus_if.chip_busy[2]); end
    checks++;
    rb_n_in[2] = 1'b0;
    bus_if.cmd_issued = 1'b1;
    tick(1);
    bus_if.cmd_issued = 1'b0;
    tick(50);
    if (bus_if.chip_busy[2] !== 1'b1) begin failures++; $display("FAIL rb_low_busy got=%b exp=1", bus_if.chip_busy[2]); end
    checks++;
    rb_n_in[2] = 1'b1;
    tick(2);
    if (bus_if.chip_busy[2] !== 1'b1) begin failures++; $display("FAIL rb_sync_delay got=%b exp=1", bus_if.chip_busy[2]); end
    checks++;
    tick(1);
    if (bus_if.chip_busy[2] !== 1'b0) begin failures++; $display("FAIL rb_rise_clear got=%b exp=0", bus_if.chip_busy[2]); end
    checks++;
    do_release();
    $display("test_twb_blank done");
  endtask

  task automatic test_timeout();
    do_grant(3'd0);
    rb_n_in[0] = 1'b0;
    bus_if.cmd_issued = 1'b1;
    tick(1);
    bus_if.cmd_issued = 1'b0;
    tick(99);
    if (bus_if.timeout_err[0] !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", bus_if.timeout_err[0]); end
    checks++;
    tick(1);
    if (bus_if.timeout_err[0] !== 1'b1 || bus_if.chip_busy[0] !== 1'b1) begin
      failures++; $display("FAIL tmo_set got=%b/%b exp=1/1", bus_if.timeout_err[0], bus_if.chip_busy[0]);
    end
    checks++;
    bus_if.err_clr = 1'b1;
    tick(1);
    bus_if.err_clr = 1'b0;
    if (bus_if.timeout_err[0] !== 1'b0) begin failures++; $display("FAIL tmo_clr got=%b exp=0", bus_if.timeout_err[0]); end
    checks++;
    bus_if.cmd_issued = 1'b1;
    tick(1);
    bus_if.cmd_issued = 1'b0;
    tick(99);
    if (bus_if.timeout_err[0] !== 1'b0) begin failures++; $display("FAIL tmo_rearm got=%b exp=0", bus_if.timeout_err[0]); end
    checks++;
    bus_if.err_clr = 1'b1;
    tick(1);
    bus_if.err_clr = 1'b0;
    if (bus_if.timeout_err[0] !== 1'b1) begin failures++; $display("FAIL tmo_set_wins got=%b exp=1", bus_if.timeout_err[0]); end
    checks++;
    bus_if.err_clr = 1'b1;
    tick(1);
    bus_if.err_clr = 1'b0;
    if (bus_if.timeout_err !== 8'h00) begin failures++; $display("FAIL tmo_clr_all got=%h exp=00", bus_if.timeout_err); end
    checks++;
    rb_n_in[0] = 1'b1;
    tick(3);
    if (bus_if.chip_busy[0] !== 1'b0) begin failures++; $display("FAIL tmo_recover got=%b exp=0", bus_if.chip_busy[0]); end
    checks++;
    do_release();
    $display("test_timeout done");
  endtask

  task automatic test_edge_cases();
    do_grant(3'd4);
    bus_if.rel = 1'b1;
    bus_if.cmd_issued = 1'b1;
    tick(1);
    bus_if.rel = 1'b0;
    bus_if.cmd_issued = 1'b0;
    if (bus_if.grant_valid !== 1'b0 || bus_if.chip_busy[4] !== 1'b1) begin
      failures++; $display("FAIL rel_cmd got=%b/%b exp=0/1", bus_if.grant_valid, bus_if.chip_busy[4]);
    end
    checks++;
    tick(12);
    if (bus_if.chip_busy[4] !== 1'b0) begin failures++; $display("FAIL rel_cmd_clear got=%b exp=0", bus_if.chip_busy[4]); end
    checks++;
    bus_if.cmd_issued = 1'b1;
    bus_if.rel = 1'b1;
    tick(1);
    bus_if.cmd_issued = 1'b0;
    bus_if.rel = 1'b0;
    if (bus_if.chip_busy[4] !== 1'b0 || bus_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ignore got=%b/%b exp=0/1", bus_if.chip_busy[4], bus_if.req_ready);
    end
    checks++;
    do_grant(3'd1);
    bus_if.rel = 1'b1;
    tick(1);
    bus_if.rel = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_chip = 3'd6;
    if (bus_if.req_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", bus_if.req_ready); end
    checks++;
    tick(1);
    bus_if.req_valid = 1'b0;
    if (cen !== 8'hFD) begin failures++; $display("FAIL hold_req_ignored got=%h exp=fd", cen); end
    checks++;
    tick(1);
    if (cen !== 8'hFF || bus_if.grant_chip !== 3'd1) begin
      failures++; $display("FAIL hold_exit got=%h/%0d exp=ff/1", cen, bus_if.grant_chip);
    end
    checks++;
    rb_n_in[6] = 1'b0;
    tick(2);
    if (bus_if.chip_busy[6] !== 1'b0) begin failures++; $display("FAIL unsol_sync got=%b exp=0", bus_if.chip_busy[6]); end
    checks++;
    tick(1);
    if (bus_if.chip_busy[6] !== 1'b1) begin failures++; $display("FAIL unsol_busy got=%b exp=1", bus_if.chip_busy[6]); end
    checks++;
    rb_n_in[6] = 1'b1;
    tick(3);
    if (bus_if.chip_busy[6] !== 1'b0) begin failures++; $display("FAIL unsol_clear got=%b exp=0", bus_if.chip_busy[6]); end
    checks++;
    $display("test_edge_cases done");
  endtask

  task automatic test_reset_mid_setup();
    rb_n_in[7] = 1'b0;
    tick(3);
    if (bus_if.chip_busy[7] !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", bus_if.chip_busy[7]); end
    checks++;
    bus_if.req_valid = 1'b1;
    bus_if.req_chip = 3'd3;
    tick(1);
    bus_if.req_valid = 1'b0;
    if (cen !== 8'hF7) begin failures++; $display("FAIL mid_setup_cen got=%h exp=f7", cen); end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (cen !== 8'hFF || bus_if.grant_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%h/%b exp=ff/0", cen, bus_if.grant_valid);
    end
    checks++;
    if (bus_if.chip_busy !== 8'h00) begin failures++; $display("FAIL async_reset_busy got=%h exp=00", bus_if.chip_busy); end
    checks++;
    rb_n_in[7] = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    if (cen !== 8'hFF || bus_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset got=%h/%b exp=ff/1", cen, bus_if.req_ready);
    end
    checks++;
    $display("test_reset_mid_setup done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_grant_timing();
    test_dq_reverse();
    test_twb_blank();
    test_timeout();
    test_edge_cases();
    test_reset_mid_setup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
